// File: rtl/exec_result_pipe_if.sv
// exec_result_pipe_if: issue, flush, forwarding and writeback bundle
// for one execution result pipe. Stat counters exist only with EXEC_PIPE_STATS_EN.
interface exec_result_pipe_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int UNIT_W = 3,
    parameter int LAT_W  = 4,
    parameter int DEPTH  = 7,
    parameter int PK_W   = 2 + UNIT_W + DATA_W + ADDR_W + LAT_W + 1
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [UNIT_W-1:0]     unit_id;
    logic [DATA_W-1:0]     result;
    logic [ADDR_W-1:0]     reg_dst;
    logic [LAT_W-1:0]      latency;
    logic                  reg_wr;
    logic                  flush;
    logic [DEPTH*PK_W-1:0] fwd_bus;
    logic [ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_en;
`ifdef EXEC_PIPE_STATS_EN
    logic [31:0]           stat_issued;
    logic [31:0]           stat_retired_wr;
    logic [31:0]           stat_rejected;
    logic [31:0]           stat_flushed;
`endif

    modport master (
        output issue_valid, unit_id, result, reg_dst, latency, reg_wr, flush,
`ifdef EXEC_PIPE_STATS_EN
        input  stat_issued, stat_retired_wr, stat_rejected, stat_flushed,
`endif
        input  issue_ready, fwd_bus, wb_addr, wb_data, wb_en
    );

    modport slave (
        input  issue_valid, unit_id, result, reg_dst, latency, reg_wr, flush,
`ifdef EXEC_PIPE_STATS_EN
        output stat_issued, stat_retired_wr, stat_rejected, stat_flushed,
`endif
        output issue_ready, fwd_bus, wb_addr, wb_data, wb_en
    );
endinterface

// File: rtl/exec_result_pipe.sv
// exec_result_pipe: DEPTH-stage result staging pipe with per-entry retire
// latency, writeback-slot scoreboard, forwarding taps and young-entry flush.
// Optional counters enabled by defining EXEC_PIPE_STATS_EN.
module exec_result_pipe #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 7,
    parameter int UNIT_W      = 3,
    parameter int LAT_W       = 4,
    parameter int DEPTH       = 7,
    parameter int FLUSH_DEPTH = 3,
    parameter int PK_W        = 2 + UNIT_W + DATA_W + ADDR_W + LAT_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    exec_result_pipe_if.slave pipe
);

    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  wr_q;
    logic [UNIT_W-1:0] unit_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] dst_q  [DEPTH];
    logic [LAT_W-1:0]  lat_q  [DEPTH];

    logic [LAT_W-1:0]  eff_lat;
    logic [DEPTH:0]    busy;
    logic              slot_busy;
    logic              accept;
    logic [DEPTH-1:0]  kill;

    logic              wb_en_d;
    logic [ADDR_W-1:0] wb_addr_d;
    logic [DATA_W-1:0] wb_data_d;
    logic              wb_en_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;

    logic [DEPTH*PK_W-1:0] fwd;

    // Clamp out-of-range latency of the incoming issue to the full depth
    always_comb begin
        eff_lat = pipe.latency;
        if (pipe.latency == '0 || int'(pipe.latency) > DEPTH)
            eff_lat = LAT_W'(DEPTH);
    end

    // busy[j]: some writing entry will retire exactly j cycles from now
    always_comb begin
        busy = '0;
        for (int k = 0; k < DEPTH; k++)
            for (int j = 0; j < DEPTH; j++)
                if (v_q[k] && wr_q[k] && int'(lat_q[k]) == k + 1 + j)
                    busy[j] = 1'b1;
    end

    // Look up the slot the incoming issue would retire into
    always_comb begin
        slot_busy = 1'b0;
        for (int j = 0; j <= DEPTH; j++)
            if (int'(eff_lat) == j)
                slot_busy = busy[j];
    end

    assign pipe.issue_ready = !(pipe.reg_wr && slot_busy);
    assign accept = pipe.issue_valid && pipe.issue_ready && !pipe.flush;

    // Stages 1..FLUSH_DEPTH are the young entries a flush discards
    always_comb begin
        kill = '0;
        for (int k = 0; k < DEPTH; k++)
            kill[k] = pipe.flush && (k + 1 <= FLUSH_DEPTH);
    end

    // Pick the (at most one) writing entry sitting at its retire stage
    always_comb begin
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (v_q[k] && wr_q[k] && !kill[k] && int'(lat_q[k]) == k + 1) begin
                wb_en_d   = 1'b1;
                wb_addr_d = dst_q[k];
                wb_data_d = data_q[k];
            end
        end
    end

    // Stage valid/write flags: load stage 1, shift, drop killed entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            wr_q <= '0;
        end else begin
            v_q[0]  <= accept;
            wr_q[0] <= pipe.reg_wr;
            for (int k = 1; k < DEPTH; k++) begin
                v_q[k]  <= v_q[k-1] && !kill[k-1];
                wr_q[k] <= wr_q[k-1];
            end
        end
    end

    // Stage payload: tag and data shift alongside the valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                unit_q[k] <= '0;
                data_q[k] <= '0;
                dst_q[k]  <= '0;
                lat_q[k]  <= '0;
            end
        end else begin
            if (accept) begin
                unit_q[0] <= pipe.unit_id;
                data_q[0] <= pipe.result;
                dst_q[0]  <= pipe.reg_dst;
                lat_q[0]  <= eff_lat;
            end
            for (int k = 1; k < DEPTH; k++) begin
                unit_q[k] <= unit_q[k-1];
                data_q[k] <= data_q[k-1];
                dst_q[k]  <= dst_q[k-1];
                lat_q[k]  <= lat_q[k-1];
            end
        end
    end

    // Registered writeback port; address/data hold between retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign pipe.wb_en   = wb_en_q;
    assign pipe.wb_addr = wb_addr_q;
    assign pipe.wb_data = wb_data_q;

    // Forwarding taps: invalid stages read as all-zero
    always_comb begin
        fwd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (v_q[k])
                fwd[k*PK_W +: PK_W] = {1'b1,
                                       int'(lat_q[k]) <= k + 1,
                                       unit_q[k],
                                       data_q[k],
                                       dst_q[k],
                                       lat_q[k],
                                       wr_q[k]};
        end
    end

    assign pipe.fwd_bus = fwd;

`ifdef EXEC_PIPE_STATS_EN
    logic [31:0] st_iss_q;
    logic [31:0] st_ret_q;
    logic [31:0] st_rej_q;
    logic [31:0] st_fl_q;
    logic [31:0] n_kill;

    // Number of live entries discarded by this cycle's flush
    always_comb begin
        n_kill = '0;
        for (int k = 0; k < DEPTH; k++)
            if (v_q[k] && kill[k])
                n_kill = n_kill + 32'd1;
    end

    // Free-running wrapping event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_iss_q <= '0;
            st_ret_q <= '0;
            st_rej_q <= '0;
            st_fl_q  <= '0;
        end else begin
            if (accept)
                st_iss_q <= st_iss_q + 32'd1;
            if (wb_en_d)
                st_ret_q <= st_ret_q + 32'd1;
            if (pipe.issue_valid && !pipe.issue_ready)
                st_rej_q <= st_rej_q + 32'd1;
            st_fl_q <= st_fl_q + n_kill;
        end
    end

    assign pipe.stat_issued     = st_iss_q;
    assign pipe.stat_retired_wr = st_ret_q;
    assign pipe.stat_rejected   = st_rej_q;
    assign pipe.stat_flushed    = st_fl_q;
`endif

endmodule

// File: tb/tb_exec_result_pipe.sv
// tb_exec_result_pipe: directed tests of staging, retire timing,
// slot collisions, flush and reset for exec_result_pipe.
module tb_exec_result_pipe;
    localparam int DATA_W      = 128;
    localparam int ADDR_W      = 7;
    localparam int UNIT_W      = 3;
    localparam int LAT_W       = 4;
    localparam int DEPTH       = 7;
    localparam int FLUSH_DEPTH = 3;
    localparam int PK_W        = 2 + UNIT_W + DATA_W + ADDR_W + LAT_W + 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    exec_result_pipe_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .UNIT_W(UNIT_W),
        .LAT_W(LAT_W), .DEPTH(DEPTH), .PK_W(PK_W)
    ) bus ();

    exec_result_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .UNIT_W(UNIT_W), .LAT_W(LAT_W),
        .DEPTH(DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH), .PK_W(PK_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.unit_id     = '0;
        bus.result      = '0;
        bus.reg_dst     = '0;
        bus.latency     = '0;
        bus.reg_wr      = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic issue(input logic [UNIT_W-1:0] u, input logic [DATA_W-1:0] d,
                         input logic [ADDR_W-1:0] a, input logic [LAT_W-1:0] l,
                         input logic w);
        bus.issue_valid = 1'b1;
        bus.unit_id     = u;
        bus.result      = d;
        bus.reg_dst     = a;
        bus.latency     = l;
        bus.reg_wr      = w;
        bus.flush       = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 2) step();
    endtask

    function automatic logic [PK_W-1:0] stg(input int k);
        return bus.fwd_bus[(k-1)*PK_W +: PK_W];
    endfunction

    function automatic logic [DEPTH-1:0] vmask();
        logic [DEPTH-1:0] m;
        logic [PK_W-1:0]  s;
        for (int k = 1; k <= DEPTH; k++) begin
            s = stg(k);
            m[k-1] = s[PK_W-1];
        end
        return m;
    endfunction

    task automatic test_reset();
        logic saw;
        rst = 1'b1;
        idle();
        step();
        checks++;
        if (bus.fwd_bus !== '0) begin
            failures++;
            $display("FAIL reset_fwd got=%h want=0", bus.fwd_bus);
        end
        checks++;
        if (bus.wb_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_wb_en got=%b want=0", bus.wb_en);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(3'(i), DATA_W'(i + 1), 7'(40 + i), 4'd7, 1'b1);
            step();
        end
        idle();
        checks++;
        if (vmask() !== 7'b0000111) begin
            failures++;
            $display("FAIL reset_preload vmask=%b want=0000111", vmask());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.fwd_bus !== '0 || bus.wb_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_async fwd_nz=%b wb_en=%b want 0/0",
                     bus.fwd_bus != '0, bus.wb_en);
        end
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (bus.wb_en === 1'b1 || vmask() !== '0) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_wb saw_activity=%b want=0", saw);
        end
    endtask

    task automatic test_fixed_latency();
        logic [DATA_W-1:0] d;
        logic [PK_W-1:0]   s;
        d = {16{8'hA5}};
        issue(3'd2, d, 7'd5, 4'd7, 1'b1);
        for (int n = 1; n <= 9; n++) begin
            step();
            idle();
            if (n <= DEPTH) begin
                s = stg(n);
                checks++;
                if (s[PK_W-1] !== 1'b1 || s[PK_W-2] !== (n == 7) ||
                    s[1+LAT_W +: ADDR_W] !== 7'd5) begin
                    failures++;
                    $display("FAIL fixed_stage%0d v=%b rdy=%b dst=%0d want v=1 rdy=%b dst=5",
                             n, s[PK_W-1], s[PK_W-2], s[1+LAT_W +: ADDR_W], n == 7);
                end
            end
            checks++;
            if (bus.wb_en !== (n == 8)) begin
                failures++;
                $display("FAIL fixed_wb_en cycle%0d got=%b want=%b", n, bus.wb_en, n == 8);
            end
            if (n == 8) begin
                checks++;
                if (bus.wb_addr !== 7'd5 || bus.wb_data !== d) begin
                    failures++;
                    $display("FAIL fixed_wb addr=%0d data=%h want 5/%h",
                             bus.wb_addr, bus.wb_data, d);
                end
            end
        end
        drain();
    endtask

    task automatic test_early_retire();
        logic [PK_W-1:0] s;
        issue(3'd5, 128'h1234_5678, 7'd9, 4'd2, 1'b1);
        for (int n = 1; n <= 9; n++) begin
            step();
            idle();
            if (n <= DEPTH) begin
                s = stg(n);
                checks++;
                if (s[PK_W-1] !== 1'b1 || s[PK_W-2] !== (n >= 2)) begin
                    failures++;
                    $display("FAIL early_stage%0d v=%b rdy=%b want v=1 rdy=%b",
                             n, s[PK_W-1], s[PK_W-2], n >= 2);
                end
            end
            checks++;
            if (bus.wb_en !== (n == 3)) begin
                failures++;
                $display("FAIL early_wb_en cycle%0d got=%b want=%b", n, bus.wb_en, n == 3);
            end
            if (n == 3) begin
                checks++;
                if (bus.wb_addr !== 7'd9 || bus.wb_data !== 128'h1234_5678) begin
                    failures++;
                    $display("FAIL early_wb addr=%0d data=%h want 9/12345678",
                             bus.wb_addr, bus.wb_data);
                end
            end
        end
        drain();
    endtask

    task automatic test_collision();
        logic [PK_W-1:0] s;
        logic            exp_en;
        logic [ADDR_W-1:0] exp_a;
        issue(3'd1, 128'h11, 7'd1, 4'd4, 1'b1);
        step();
        idle();
        step();
        issue(3'd2, 128'h22, 7'd2, 4'd2, 1'b1);
        #1;
        checks++;
        if (bus.issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL collide_lat2_wr1 ready=%b want=0", bus.issue_ready);
        end
        bus.reg_wr = 1'b0;
        #1;
        checks++;
        if (bus.issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL collide_lat2_wr0 ready=%b want=1", bus.issue_ready);
        end
        bus.reg_wr  = 1'b1;
        bus.latency = 4'd3;
        #1;
        checks++;
        if (bus.issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL collide_lat3 ready=%b want=1", bus.issue_ready);
        end
        step();
        issue(3'd3, 128'h33, 7'd3, 4'd2, 1'b0);
        #1;
        checks++;
        if (bus.issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL nowr_ready ready=%b want=1", bus.issue_ready);
        end
        step();
        idle();
        s = stg(1);
        checks++;
        if (s[PK_W-1] !== 1'b1 || s[0] !== 1'b0 || s[1+LAT_W +: ADDR_W] !== 7'd3) begin
            failures++;
            $display("FAIL nowr_stage1 v=%b wr=%b dst=%0d want 1/0/3",
                     s[PK_W-1], s[0], s[1+LAT_W +: ADDR_W]);
        end
        for (int n = 4; n <= 8; n++) begin
            exp_en = (n == 5) || (n == 6);
            exp_a  = (n == 5) ? 7'd1 : 7'd2;
            checks++;
            if (bus.wb_en !== exp_en || (exp_en && bus.wb_addr !== exp_a)) begin
                failures++;
                $display("FAIL collide_wb cycle%0d en=%b addr=%0d want en=%b addr=%0d",
                         n, bus.wb_en, bus.wb_addr, exp_en, exp_a);
            end
            step();
        end
        drain();
    endtask

    task automatic test_flush();
        logic [DEPTH-1:0] exp_m;
        issue(3'd0, 128'hA0, 7'd10, 4'd7, 1'b1);
        step();
        idle();
        step();
        issue(3'd0, 128'hA1, 7'd11, 4'd7, 1'b1);
        step();
        idle();
        step();
        issue(3'd0, 128'hA2, 7'd12, 4'd7, 1'b1);
        step();
        idle();
        checks++;
        if (vmask() !== 7'b0010101) begin
            failures++;
            $display("FAIL flush_pre vmask=%b want=0010101", vmask());
        end
        issue(3'd0, 128'hA3, 7'd13, 4'd7, 1'b1);
        bus.flush = 1'b1;
        for (int n = 6; n <= 11; n++) begin
            step();
            idle();
            exp_m = (n == 6) ? 7'b0100000 : (n == 7) ? 7'b1000000 : 7'b0;
            checks++;
            if (vmask() !== exp_m) begin
                failures++;
                $display("FAIL flush_vmask cycle%0d got=%b want=%b", n, vmask(), exp_m);
            end
            checks++;
            if (bus.wb_en !== (n == 8) || (n == 8 && bus.wb_addr !== 7'd10)) begin
                failures++;
                $display("FAIL flush_wb cycle%0d en=%b addr=%0d want en=%b addr=10",
                         n, bus.wb_en, bus.wb_addr, n == 8);
            end
        end
        drain();
    endtask

    task automatic test_lat_clamp();
        logic [PK_W-1:0]   s;
        logic              exp_en;
        logic [ADDR_W-1:0] exp_a;
        issue(3'd4, 128'hC0, 7'd20, 4'd0, 1'b1);
        step();
        issue(3'd4, 128'hC1, 7'd21, 4'd12, 1'b1);
        s = stg(1);
        checks++;
        if (s[1 +: LAT_W] !== 4'd7 || s[PK_W-2] !== 1'b0) begin
            failures++;
            $display("FAIL clamp_lat0 lat=%0d rdy=%b want 7/0", s[1 +: LAT_W], s[PK_W-2]);
        end
        for (int n = 2; n <= 10; n++) begin
            step();
            idle();
            if (n == 2) begin
                s = stg(1);
                checks++;
                if (s[1 +: LAT_W] !== 4'd7 || s[1+LAT_W +: ADDR_W] !== 7'd21) begin
                    failures++;
                    $display("FAIL clamp_lat12 lat=%0d dst=%0d want 7/21",
                             s[1 +: LAT_W], s[1+LAT_W +: ADDR_W]);
                end
            end
            exp_en = (n == 8) || (n == 9);
            exp_a  = (n == 8) ? 7'd20 : 7'd21;
            checks++;
            if (bus.wb_en !== exp_en || (exp_en && bus.wb_addr !== exp_a)) begin
                failures++;
                $display("FAIL clamp_wb cycle%0d en=%b addr=%0d want en=%b addr=%0d",
                         n, bus.wb_en, bus.wb_addr, exp_en, exp_a);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic              exp_en;
        logic [ADDR_W-1:0] exp_a;
        for (int n = 0; n <= 16; n++) begin
            exp_en = (n >= 8) && (n <= 15);
            exp_a  = 7'(30 + n - 8);
            checks++;
            if (bus.wb_en !== exp_en ||
                (exp_en && (bus.wb_addr !== exp_a || bus.wb_data !== DATA_W'(n - 8)))) begin
                failures++;
                $display("FAIL b2b_wb cycle%0d en=%b addr=%0d data=%h want en=%b addr=%0d",
                         n, bus.wb_en, bus.wb_addr, bus.wb_data, exp_en, exp_a);
            end
            if (n < 8) begin
                issue(3'd6, DATA_W'(n), 7'(30 + n), 4'd7, 1'b1);
                #1;
                checks++;
                if (bus.issue_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready cycle%0d ready=%b want=1", n, bus.issue_ready);
                end
            end else begin
                idle();
            end
            step();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fixed_latency();
        test_early_retire();
        test_collision();
        test_flush();
        test_lat_clamp();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
